dco_bank_ramp_ctrl: RTL

Sequencer in front of the 5x5 DCO capacitor-bank row/column coder. It accepts a target bank word from the frequency-control logic and ramps the coder word towards it. Each move is limited to a programmable step size, with a programmable dwell between moves, so that large retunes never produce a single large capacitance jump. It drives the coder's word input and enable and reports completion through a valid/ready request plus a done pulse.

---
 rtl/dco_bank_ramp_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/dco_bank_ramp_ctrl.sv
// Ramps the DCO bank word towards a requested target in bounded steps with a dwell between moves.
// Request accepted on edge N gives the first word_en in cycle N+1; done follows the final word_en by one cycle.
module dco_bank_ramp_ctrl #(
  parameter int WIDTH    = 5,
  parameter int MAX      = 25,
  parameter int DWELL_W  = 4,
  parameter int RST_WORD = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [WIDTH-1:0]   req_target,
  output logic               req_ready,
  input  logic [2:0]         step_size,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic [WIDTH-1:0]   word_out,
  output logic               word_en,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               clamp_flag
);

  typedef enum logic [1:0] {IDLE, STEP, DWELL, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_WORD);

  state_t             state;
  logic [WIDTH-1:0]   tgt;
  logic [2:0]         step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] cnt;
  logic               clr_r;
  logic               ab_r;

  logic [WIDTH-1:0]   tgt_in;
  logic               clr_in;
  logic [2:0]         step_in;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     mag;
  logic [WIDTH:0]     step_ext;
  logic [WIDTH:0]     delta;
  logic [WIDTH-1:0]   next_word;

  always_comb begin
    clr_in  = (req_target > MAX_W);
    tgt_in  = clr_in ? MAX_W : req_target;
    step_in = (step_size == 3'd0) ? 3'd1 : step_size;
  end

  // diff is a two's-complement value: its MSB is the sign (target below word).
  // Limiting delta to |diff| is what prevents overshoot and keeps word_out in range.
  always_comb begin
    diff      = {1'b0, tgt} - {1'b0, word_out};
    mag       = diff[WIDTH] ? (~diff + 1'b1) : diff;
    step_ext  = {{(WIDTH-2){1'b0}}, step_r};
    delta     = (step_ext < mag) ? step_ext : mag;
    next_word = diff[WIDTH] ? (word_out - delta[WIDTH-1:0])
                            : (word_out + delta[WIDTH-1:0]);
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state == STEP) || (state == DWELL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_out   <= RST_W;
      word_en    <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      clamp_flag <= 1'b0;
      cnt        <= '0;
      tgt        <= RST_W;
      step_r     <= 3'd1;
      dwell_r    <= '0;
      clr_r      <= 1'b0;
      ab_r       <= 1'b0;
    end else begin
      word_en    <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      clamp_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            tgt     <= tgt_in;
            clr_r   <= clr_in;
            step_r  <= step_in;
            dwell_r <= dwell;
            ab_r    <= 1'b0;
            state   <= (tgt_in == word_out) ? DONE : STEP;
          end
        end
        STEP: begin
          // Abort wins over a step due on the same edge.
          if (abort) begin
            ab_r  <= 1'b1;
            state <= DONE;
          end else begin
            word_out <= next_word;
            word_en  <= 1'b1;
            if (next_word == tgt) begin
              state <= DONE;
            end else if (dwell_r == '0) begin
              state <= STEP;
            end else begin
              cnt   <= dwell_r;
              state <= DWELL;
            end
          end
        end
        DWELL: begin
          if (abort) begin
            ab_r  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == DWELL_W'(1)) state <= STEP;
          end
        end
        DONE: begin
          done       <= 1'b1;
          aborted    <= ab_r;
          clamp_flag <= clr_r;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
